// File: rtl/link_pkg.sv
// link_pkg: shared link constants, tx state encoding and odd parity.
// Imported by the link transmit scheduler and the link receiver.
package link_pkg;

    localparam int   LINK_DATA_W     = 8;
    localparam logic LINK_START_LVL  = 1'b1;
    localparam logic LINK_STOP_LVL   = 1'b1;
    localparam logic LINK_IDLE_LVL   = 1'b0;
    localparam int   LINK_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4,
        TX_GAP    = 3'd5
    } tx_state_e;

    // parity bit that makes data plus parity XOR to 1
    function automatic logic odd_parity(input logic [LINK_DATA_W-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/link_tx_scheduler_if.sv
// link_tx_scheduler_if: per-requester byte valid/ready bundle.
// master = requesters, slave = transmit scheduler.
interface link_tx_scheduler_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/link_rr_arbiter.sv
// link_rr_arbiter: NUM_REQ-way round-robin arbiter; the search starts
// at the pointer, which moves past the winner on each accept strobe.
module link_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               arst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_accept,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IW-1:0]      o_idx,
    output logic               o_any
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_j;
    logic [IW-1:0] w_idx;
    logic          w_any;

    // first requesting index at or after the pointer, wrapping
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        w_j   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = IW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_any && i_req[w_j]) begin
                w_any = 1'b1;
                w_idx = w_j;
            end
        end
    end

    assign o_any = w_any;
    assign o_idx = w_idx;
    assign o_gnt = w_any ? (NUM_REQ'(1) << w_idx) : '0;

    // move the pointer just past the accepted requester
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_ptr <= '0;
        end else if (i_accept) begin
            r_ptr <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/link_tx_scheduler.sv
// link_tx_scheduler: round-robin byte arbiter and 11-bit frame serializer.
// Optional LINK_TX_PARITY_INJECT_EN adds inject_err to corrupt parity.
module link_tx_scheduler
    import link_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int IDLE_GAP   = 0,
    localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                clk,
    input  logic                arst,
    link_tx_scheduler_if.slave  req_if,
`ifdef LINK_TX_PARITY_INJECT_EN
    input  logic                inject_err,
`endif
    output logic                tx_out,
    output logic                busy,
    output logic [IW-1:0]       grant_id,
    output logic                frame_done
);

    localparam logic       GAP_EN   = (IDLE_GAP > 0);
    localparam logic [3:0] GAP_LAST = 4'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    tx_state_e              r_state;
    logic [2:0]             r_bcnt;
    logic [3:0]             r_gcnt;
    logic [LINK_DATA_W-1:0] r_sh;
    logic                   r_par;

    logic                   w_acc;
    logic                   w_fire;
    logic                   w_any;
    logic [NUM_REQ-1:0]     w_gnt;
    logic [IW-1:0]          w_idx;
    logic [LINK_DATA_W-1:0] w_byte;
    logic                   w_par;

    link_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk      (clk),
        .arst     (arst),
        .i_req    (req_if.req_valid),
        .i_accept (w_fire),
        .o_gnt    (w_gnt),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    // accept window: idle, stop bit with no gap, or the last gap bit
    always_comb begin
        w_acc = 1'b0;
        case (r_state)
            TX_IDLE: w_acc = 1'b1;
            TX_STOP: w_acc = !GAP_EN;
            TX_GAP:  w_acc = (r_gcnt == GAP_LAST);
            default: w_acc = 1'b0;
        endcase
    end

    assign w_fire = w_acc && w_any && !arst;
    assign req_if.req_ready = w_fire ? w_gnt : '0;
    assign w_byte = req_if.req_data[int'(w_idx)*DATA_WIDTH +: LINK_DATA_W];

`ifdef LINK_TX_PARITY_INJECT_EN
    assign w_par = odd_parity(w_byte) ^ inject_err;
`else
    assign w_par = odd_parity(w_byte);
`endif

    // frame sequencer; tx_out is the registered level of the next bit
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state    <= TX_IDLE;
            r_bcnt     <= '0;
            r_gcnt     <= '0;
            r_sh       <= '0;
            r_par      <= 1'b0;
            tx_out     <= LINK_IDLE_LVL;
            busy       <= 1'b0;
            grant_id   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_fire) begin
                r_state  <= TX_START;
                tx_out   <= LINK_START_LVL;
                busy     <= 1'b1;
                r_sh     <= w_byte;
                r_par    <= w_par;
                grant_id <= w_idx;
            end else begin
                case (r_state)
                    TX_START: begin
                        r_state <= TX_DATA;
                        r_bcnt  <= '0;
                        tx_out  <= r_sh[0];
                        r_sh    <= r_sh >> 1;
                    end
                    TX_DATA: begin
                        if (r_bcnt == 3'd7) begin
                            r_state <= TX_PARITY;
                            tx_out  <= r_par;
                        end else begin
                            r_bcnt <= r_bcnt + 3'd1;
                            tx_out <= r_sh[0];
                            r_sh   <= r_sh >> 1;
                        end
                    end
                    TX_PARITY: begin
                        r_state    <= TX_STOP;
                        tx_out     <= LINK_STOP_LVL;
                        frame_done <= 1'b1;
                    end
                    TX_STOP: begin
                        tx_out <= LINK_IDLE_LVL;
                        r_gcnt <= '0;
                        if (GAP_EN) begin
                            r_state <= TX_GAP;
                        end else begin
                            r_state <= TX_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    TX_GAP: begin
                        tx_out <= LINK_IDLE_LVL;
                        if (r_gcnt == GAP_LAST) begin
                            r_state <= TX_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_gcnt <= r_gcnt + 4'd1;
                        end
                    end
                    default: begin
                        r_state <= TX_IDLE;
                        tx_out  <= LINK_IDLE_LVL;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
